// File: rtl/tag_ram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tag_ram_ctrl_pkg
// Shared types and helpers for the tag RAM sequencing controller.
//   state_t   : controller FSM states (IDLE / LOOK / FLUSH)
//   valid_bit : position of the valid flag inside a RAM word of a given width
// -----------------------------------------------------------------------------
package tag_ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOOK  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Valid flag is the MSB of the RAM word; the tag occupies the bits below it.
  function automatic int valid_bit(input int dwidth);
    return dwidth - 1;
  endfunction

endpackage

// File: rtl/tag_ram_ctrl_if.sv
// -----------------------------------------------------------------------------
// tag_ram_ctrl_if
// Cache-side bus of the tag RAM controller.
//   lookup : req_valid/req_ready/req_index/req_tag -> rsp_valid/rsp_hit/rsp_index
//   fill   : fill_valid/fill_index/fill_tag -> fill_ready
//   flush  : inv_all -> flush_busy/flush_done
//   stats  : hit_count/miss_count
// modport master : cache lookup path (drives requests)
// modport slave  : the controller
// -----------------------------------------------------------------------------
interface tag_ram_ctrl_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 7,
  parameter int CNT_W  = 8
);
  localparam int TAG_W = DWIDTH - 1;

  logic              req_valid;
  logic              req_ready;
  logic [AWIDTH-1:0] req_index;
  logic [TAG_W-1:0]  req_tag;

  logic              rsp_valid;
  logic              rsp_hit;
  logic [AWIDTH-1:0] rsp_index;

  logic              fill_valid;
  logic              fill_ready;
  logic [AWIDTH-1:0] fill_index;
  logic [TAG_W-1:0]  fill_tag;

  logic              inv_all;
  logic              flush_busy;
  logic              flush_done;

  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport master (
    output req_valid, req_index, req_tag,
    output fill_valid, fill_index, fill_tag,
    output inv_all,
    input  req_ready, rsp_valid, rsp_hit, rsp_index,
    input  fill_ready, flush_busy, flush_done,
    input  hit_count, miss_count
  );

  modport slave (
    input  req_valid, req_index, req_tag,
    input  fill_valid, fill_index, fill_tag,
    input  inv_all,
    output req_ready, rsp_valid, rsp_hit, rsp_index,
    output fill_ready, flush_busy, flush_done,
    output hit_count, miss_count
  );

endinterface

// File: rtl/tag_ram_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating statistics counter: counts inc pulses, sticks at all-ones,
// synchronous clear has priority over increment.
//   clock, reset_n : clock and asynchronous active-low reset
//   inc            : increment request
//   clr            : clear to zero
//   count          : current value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/tag_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tag_ram_ctrl
// Sequencing controller for a synchronous-read tag RAM (address sampled on
// the edge, data out the following cycle). Serves tag lookups, single-entry
// fills and a whole-array flush, and keeps saturating hit/miss statistics.
//   clock, reset_n : clock and asynchronous active-low reset
//   bus            : cache-side request/response bus (slave modport)
//   ram_addr       : RAM address (holds its last value when idle)
//   ram_din        : RAM write data ({valid, tag})
//   ram_we         : RAM write enable
//   ram_dout       : RAM read data, valid the cycle after ram_addr is sampled
// -----------------------------------------------------------------------------
module tag_ram_ctrl
  import tag_ram_ctrl_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 7,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  tag_ram_ctrl_if.slave     bus,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  localparam int TAG_W     = DWIDTH - 1;
  localparam int VALID_BIT = valid_bit(DWIDTH);

  state_t            state_reg;
  logic              pending_reg;
  logic [AWIDTH-1:0] flush_idx_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [AWIDTH-1:0] index_reg;
  logic              rsp_valid_reg;
  logic              rsp_hit_reg;
  logic [AWIDTH-1:0] rsp_index_reg;
  logic              flush_done_reg;
  logic [AWIDTH-1:0] addr_reg;

  logic flush_go;
  logic fill_go;
  logic req_go;
  logic look_hit;

  // A pending flush outranks fills, and fills outrank lookups.
  assign flush_go      = (state_reg == IDLE) && pending_reg;
  assign fill_go       = (state_reg == IDLE) && !pending_reg && bus.fill_valid;
  assign bus.req_ready = (state_reg == IDLE) && !pending_reg && !bus.fill_valid;
  assign req_go        = bus.req_ready && bus.req_valid;
  assign bus.fill_ready = fill_go;

  // In LOOK, ram_dout carries the word addressed at the accepting edge.
  assign look_hit = ram_dout[VALID_BIT] && (ram_dout[TAG_W-1:0] == tag_reg);

  always_comb begin
    ram_addr = addr_reg;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (state_reg == FLUSH) begin
      ram_we   = 1'b1;
      ram_addr = flush_idx_reg;
    end else if (fill_go) begin
      ram_we   = 1'b1;
      ram_addr = bus.fill_index;
      ram_din  = {1'b1, bus.fill_tag};
    end else if (req_go) begin
      ram_addr = bus.req_index;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      pending_reg    <= 1'b0;
      flush_idx_reg  <= '0;
      tag_reg        <= '0;
      index_reg      <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_hit_reg    <= 1'b0;
      rsp_index_reg  <= '0;
      flush_done_reg <= 1'b0;
      addr_reg       <= '0;
    end else begin
      addr_reg       <= ram_addr;
      rsp_valid_reg  <= 1'b0;
      flush_done_reg <= 1'b0;
      // Requests arriving during FLUSH are absorbed by the running flush.
      if (bus.inv_all && (state_reg != FLUSH)) begin
        pending_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (flush_go) begin
            // Overrides a same-cycle inv_all: that request is covered too.
            pending_reg   <= 1'b0;
            flush_idx_reg <= '0;
            state_reg     <= FLUSH;
          end else if (req_go) begin
            tag_reg   <= bus.req_tag;
            index_reg <= bus.req_index;
            state_reg <= LOOK;
          end
        end
        LOOK: begin
          rsp_valid_reg <= 1'b1;
          rsp_hit_reg   <= look_hit;
          rsp_index_reg <= index_reg;
          state_reg     <= IDLE;
        end
        FLUSH: begin
          flush_idx_reg <= flush_idx_reg + AWIDTH'(1);
          if (&flush_idx_reg) begin
            flush_done_reg <= 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_hit    = rsp_hit_reg;
  assign bus.rsp_index  = rsp_index_reg;
  assign bus.flush_done = flush_done_reg;
  assign bus.flush_busy = pending_reg || (state_reg == FLUSH);

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     ((state_reg == LOOK) && look_hit),
    .clr     (flush_go),
    .count   (bus.hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     ((state_reg == LOOK) && !look_hit),
    .clr     (flush_go),
    .count   (bus.miss_count)
  );

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tag_ram_ctrl
// Self-checking bench for tag_ram_ctrl with a synchronous-read RAM model.
// Lookup expectations are queued when a request is accepted and compared by
// a response monitor when rsp_valid appears.
// -----------------------------------------------------------------------------
module tb_tag_ram_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 7;
  localparam int CW    = 8;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic          hit;
    logic [AW-1:0] idx;
    int            cyc;
  } exp_t;

  logic          clock;
  logic          reset_n;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  int   checks;
  int   passes;
  int   cyc;
  exp_t sb_q[$];

  tag_ram_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW), .CNT_W(CW)) bus ();

  tag_ram_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .CNT_W(CW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  // Preloaded RAM image: index 5 holds tag 0x15 but with the valid bit clear.
  logic [DW-1:0] ram_mem [DEPTH] = '{7'h00, 7'h00, 7'h00, 7'h00,
                                     7'h00, 7'h15, 7'h00, 7'h00};

  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Response monitor / scoreboard
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && bus.rsp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL rsp_unexpected: got rsp idx=%0d hit=%0b, required no response", bus.rsp_index, bus.rsp_hit);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (bus.rsp_hit !== e.hit) $display("FAIL rsp_hit idx=%0d: got %0b, required %0b", e.idx, bus.rsp_hit, e.hit);
        else passes++;
        checks++;
        if (bus.rsp_index !== e.idx) $display("FAIL rsp_index: got %0d, required %0d", bus.rsp_index, e.idx);
        else passes++;
        checks++;
        if (cyc !== e.cyc) $display("FAIL rsp_latency idx=%0d: got cycle %0d, required %0d", e.idx, cyc, e.cyc);
        else passes++;
        $display("rsp idx=%0d hit=%0b hit_count=%0d miss_count=%0d", bus.rsp_index, bus.rsp_hit, bus.hit_count, bus.miss_count);
      end
    end
  end

  task automatic issue_lookup(input logic [AW-1:0] idx, input logic [DW-2:0] tag, input logic exp_hit);
    bit got = 0;
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_index = idx;
    bus.req_tag   = tag;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (bus.req_ready) begin
        sb_q.push_back('{hit: exp_hit, idx: idx, cyc: cyc + 2});
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      $display("FAIL lookup_accept idx=%0d: got no req_ready in 20 cycles, required accept", idx);
    end
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bit empty = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (sb_q.size() == 0) begin
        empty = 1;
        break;
      end
    end
    if (!empty) begin
      checks++;
      $display("FAIL rsp_timeout: got %0d outstanding responses, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_fill(input logic [AW-1:0] idx, input logic [DW-2:0] tag);
    @(posedge clock); #1;
    bus.fill_valid = 1'b1;
    bus.fill_index = idx;
    bus.fill_tag   = tag;
    @(negedge clock);
    checks++;
    if (bus.fill_ready !== 1'b1) $display("FAIL fill_ready idx=%0d: got %0b, required 1", idx, bus.fill_ready);
    else passes++;
    $display("fill idx=%0d tag=0x%0h", idx, tag);
    @(posedge clock); #1;
    bus.fill_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_index  = '0;
    bus.req_tag    = '0;
    bus.fill_valid = 1'b0;
    bus.fill_index = '0;
    bus.fill_tag   = '0;
    bus.inv_all    = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (bus.rsp_valid !== 1'b0)  $display("FAIL reset_rsp_valid: got %0b, required 0", bus.rsp_valid); else passes++;
    checks++; if (bus.flush_busy !== 1'b0) $display("FAIL reset_flush_busy: got %0b, required 0", bus.flush_busy); else passes++;
    checks++; if (bus.flush_done !== 1'b0) $display("FAIL reset_flush_done: got %0b, required 0", bus.flush_done); else passes++;
    checks++; if (bus.hit_count !== 8'd0)  $display("FAIL reset_hit_count: got %0d, required 0", bus.hit_count); else passes++;
    checks++; if (bus.miss_count !== 8'd0) $display("FAIL reset_miss_count: got %0d, required 0", bus.miss_count); else passes++;
    checks++; if (ram_we !== 1'b0)         $display("FAIL reset_ram_we: got %0b, required 0", ram_we); else passes++;
    $display("reset checked");
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_fill_lookup();
    @(posedge clock); #1;
    bus.fill_valid = 1'b1;
    bus.fill_index = 3'd2;
    bus.fill_tag   = 6'h15;
    @(negedge clock);
    checks++; if (ram_we !== 1'b1)      $display("FAIL fill_ram_we: got %0b, required 1", ram_we); else passes++;
    checks++; if (ram_addr !== 3'd2)    $display("FAIL fill_ram_addr: got %0d, required 2", ram_addr); else passes++;
    checks++; if (ram_din !== 7'h55)    $display("FAIL fill_ram_din: got 0x%0h, required 0x55", ram_din); else passes++;
    checks++; if (bus.fill_ready !== 1) $display("FAIL fill_ready: got %0b, required 1", bus.fill_ready); else passes++;
    $display("fill idx=2 tag=0x15");
    @(posedge clock); #1;
    bus.fill_valid = 1'b0;
    issue_lookup(3'd2, 6'h15, 1'b1);
    drain();
    checks++; if (bus.hit_count !== 8'd1) $display("FAIL hit_count_first: got %0d, required 1", bus.hit_count); else passes++;
  endtask

  task automatic test_miss();
    issue_lookup(3'd2, 6'h14, 1'b0);
    drain();
    checks++; if (bus.miss_count !== 8'd1) $display("FAIL miss_count_tag: got %0d, required 1", bus.miss_count); else passes++;
    issue_lookup(3'd5, 6'h15, 1'b0);
    drain();
    checks++; if (bus.miss_count !== 8'd2) $display("FAIL miss_count_invalid: got %0d, required 2", bus.miss_count); else passes++;
    checks++; if (bus.hit_count !== 8'd1)  $display("FAIL hit_count_after_miss: got %0d, required 1", bus.hit_count); else passes++;
  endtask

  task automatic test_fill_vs_lookup();
    @(posedge clock); #1;
    bus.fill_valid = 1'b1; bus.fill_index = 3'd3; bus.fill_tag = 6'h0a;
    bus.req_valid  = 1'b1; bus.req_index  = 3'd3; bus.req_tag  = 6'h0a;
    @(negedge clock);
    checks++; if (bus.fill_ready !== 1'b1) $display("FAIL prio_fill_ready: got %0b, required 1", bus.fill_ready); else passes++;
    checks++; if (bus.req_ready !== 1'b0)  $display("FAIL prio_req_ready: got %0b, required 0", bus.req_ready); else passes++;
    @(posedge clock); #1;
    bus.fill_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      $display("FAIL prio_req_next: got req_ready %0b, required 1", bus.req_ready);
    end else begin
      passes++;
      sb_q.push_back('{hit: 1'b1, idx: 3'd3, cyc: cyc + 2});
    end
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    drain();
    checks++; if (bus.hit_count !== 8'd2) $display("FAIL hit_count_prio: got %0d, required 2", bus.hit_count); else passes++;
  endtask

  task automatic test_flush_during_look();
    bit got = 0;
    bit done = 0;
    int wr = 0;
    @(posedge clock); #1;
    bus.req_valid = 1'b1; bus.req_index = 3'd3; bus.req_tag = 6'h0a;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (bus.req_ready) begin
        sb_q.push_back('{hit: 1'b1, idx: 3'd3, cyc: cyc + 2});
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      $display("FAIL flush_look_accept: got no req_ready, required accept");
    end
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    bus.inv_all   = 1'b1;
    @(posedge clock); #1;
    bus.inv_all = 1'b0;
    @(negedge clock);
    checks++; if (bus.flush_busy !== 1'b1) $display("FAIL flush_pending_busy: got %0b, required 1", bus.flush_busy); else passes++;
    checks++; if (bus.req_ready !== 1'b0)  $display("FAIL flush_pending_ready: got %0b, required 0", bus.req_ready); else passes++;
    checks++; if (ram_we !== 1'b0)         $display("FAIL flush_pending_we: got %0b, required 0", ram_we); else passes++;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (bus.flush_done) begin
        done = 1;
        break;
      end
      if (ram_we) begin
        checks++; if (ram_addr !== AW'(wr)) $display("FAIL flush_addr: got %0d, required %0d", ram_addr, wr); else passes++;
        checks++; if (ram_din !== 7'h00)    $display("FAIL flush_din: got 0x%0h, required 0", ram_din); else passes++;
        checks++; if (bus.fill_ready !== 1'b0 || bus.req_ready !== 1'b0)
                    $display("FAIL flush_stall: got fill_ready %0b req_ready %0b, required 0 0", bus.fill_ready, bus.req_ready);
                  else passes++;
        $display("flush write idx=%0d", ram_addr);
        wr++;
      end
      bus.inv_all = (wr == 3);
    end
    bus.inv_all = 1'b0;
    checks++; if (!done)   $display("FAIL flush_done_timeout: got no flush_done, required pulse"); else passes++;
    checks++; if (wr !== 8) $display("FAIL flush_writes: got %0d, required 8", wr); else passes++;
    checks++; if (bus.hit_count !== 8'd0)  $display("FAIL flush_hit_clear: got %0d, required 0", bus.hit_count); else passes++;
    checks++; if (bus.miss_count !== 8'd0) $display("FAIL flush_miss_clear: got %0d, required 0", bus.miss_count); else passes++;
    @(negedge clock);
    checks++; if (bus.flush_done !== 1'b0) $display("FAIL flush_done_pulse: got %0b, required 0", bus.flush_done); else passes++;
    checks++; if (bus.flush_busy !== 1'b0) $display("FAIL flush_absorb_busy: got %0b, required 0", bus.flush_busy); else passes++;
    checks++; if (ram_we !== 1'b0)         $display("FAIL flush_absorb_we: got %0b, required 0", ram_we); else passes++;
    issue_lookup(3'd2, 6'h15, 1'b0);
    drain();
    checks++; if (bus.miss_count !== 8'd1) $display("FAIL miss_after_flush: got %0d, required 1", bus.miss_count); else passes++;
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int last = -1;
    do_fill(3'd0, 6'h01);
    @(posedge clock); #1;
    bus.req_valid = 1'b1; bus.req_index = 3'd0; bus.req_tag = 6'h01;
    for (int n = 0; n < 2000 && accepts < 256; n++) begin
      @(negedge clock);
      if (bus.req_ready) begin
        sb_q.push_back('{hit: 1'b1, idx: 3'd0, cyc: cyc + 2});
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 2) $display("FAIL b2b_spacing: got %0d cycles, required 2", cyc - last);
          else passes++;
        end
        last = cyc;
        accepts++;
      end
    end
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    checks++; if (accepts !== 256) $display("FAIL b2b_accepts: got %0d, required 256", accepts); else passes++;
    drain();
    checks++; if (bus.hit_count !== 8'd255) $display("FAIL hit_saturate: got %0d, required 255", bus.hit_count); else passes++;
    checks++; if (bus.miss_count !== 8'd1)  $display("FAIL miss_hold: got %0d, required 1", bus.miss_count); else passes++;
  endtask

  task automatic test_reset_mid_flush();
    bit seen = 0;
    for (int i = 0; i < DEPTH; i++) do_fill(AW'(i), 6'(6'h20 + i));
    @(posedge clock); #1;
    bus.inv_all = 1'b1;
    @(posedge clock); #1;
    bus.inv_all = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (ram_we && ram_addr == 3'd4) begin
        seen = 1;
        break;
      end
    end
    checks++; if (!seen) $display("FAIL midflush_reach4: got no write to index 4, required one"); else passes++;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.flush_busy !== 1'b0) $display("FAIL midflush_busy: got %0b, required 0", bus.flush_busy); else passes++;
    checks++; if (ram_we !== 1'b0)         $display("FAIL midflush_we: got %0b, required 0", ram_we); else passes++;
    checks++; if (ram_addr !== 3'd0)       $display("FAIL midflush_addr: got %0d, required 0", ram_addr); else passes++;
    checks++; if (bus.hit_count !== 8'd0 || bus.miss_count !== 8'd0)
                $display("FAIL midflush_counts: got %0d/%0d, required 0/0", bus.hit_count, bus.miss_count);
              else passes++;
    $display("reset asserted mid-flush");
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) issue_lookup(AW'(i), 6'(6'h20 + i), 1'b0);
    for (int i = 5; i < DEPTH; i++) issue_lookup(AW'(i), 6'(6'h20 + i), 1'b1);
    drain();
    checks++; if (bus.hit_count !== 8'd3)  $display("FAIL midflush_hits: got %0d, required 3", bus.hit_count); else passes++;
    checks++; if (bus.miss_count !== 8'd4) $display("FAIL midflush_misses: got %0d, required 4", bus.miss_count); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_fill_lookup();
    test_miss();
    test_fill_vs_lookup();
    test_flush_during_look();
    test_back_to_back();
    test_reset_mid_flush();
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
